// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/add/sub/compare, iterative shift-add MUL
// and restoring DIV with a start/busy/done handshake.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | waiting for start; fast ops complete here in one edge
//  RUN   | MUL/DIV iterating one bit per edge until the counter hits zero
module seq_alu #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2:0]           alu_op,
   input  logic [WIDTH-1:0]     data_in1,
   input  logic [WIDTH-1:0]     data_in2,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   result,
   output logic                 zero,
   output logic                 div0
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_MUL = 3'b100;
   localparam logic [2:0] OP_DIV = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   localparam int CW = $clog2(WIDTH);

   logic [0:0]           state;
   logic                 is_div;
   logic [CW-1:0]        cnt;
   logic [2*WIDTH-1:0]   acc;
   logic [2*WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]     opa;      // multiplier (MUL) or dividend/quotient shifter (DIV)
   logic [WIDTH-1:0]     divisor;
   logic [WIDTH-1:0]     rem;

   logic [2*WIDTH-1:0]   ext_a;
   logic [2*WIDTH-1:0]   ext_b;
   logic [2*WIDTH-1:0]   fast_res;
   logic                 slt;
   logic [2*WIDTH-1:0]   mul_acc_nxt;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH-1:0]     div_diff;
   logic                 div_ge;
   logic [WIDTH-1:0]     rem_nxt;
   logic [WIDTH-1:0]     quo_nxt;
   logic [2*WIDTH-1:0]   slow_res;
   logic                 is_slow_op;

   assign busy       = (state == RUN);
   assign is_slow_op = (alu_op == OP_MUL) || (alu_op == OP_DIV);
   assign slt        = $signed(data_in1) < $signed(data_in2);

   always_comb begin
      ext_a    = {{WIDTH{1'b0}}, data_in1};
      ext_b    = {{WIDTH{1'b0}}, data_in2};
      fast_res = '0;
      case (alu_op)
         OP_AND:  fast_res = ext_a & ext_b;
         OP_OR:   fast_res = ext_a | ext_b;
         OP_ADD:  fast_res = ext_a + ext_b;
         OP_SUB:  fast_res = ext_a - ext_b;
         OP_XOR:  fast_res = ext_a ^ ext_b;
         OP_SLT:  fast_res = {{(2*WIDTH-1){1'b0}}, slt};
         default: fast_res = '0;
      endcase
   end

   // Remainder stays below the divisor (or holds the top dividend bits when
   // the divisor is zero), so a WIDTH-bit difference is sufficient.
   always_comb begin
      mul_acc_nxt = opa[0] ? (acc + mcand) : acc;
      div_shift   = {rem, opa[WIDTH-1]};
      div_ge      = (div_shift >= {1'b0, divisor});
      div_diff    = div_shift[WIDTH-1:0] - divisor;
      rem_nxt     = div_ge ? div_diff : div_shift[WIDTH-1:0];
      quo_nxt     = {opa[WIDTH-2:0], div_ge};
      slow_res    = is_div ? {rem_nxt, quo_nxt} : mul_acc_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         done    <= 1'b0;
         result  <= '0;
         zero    <= 1'b0;
         div0    <= 1'b0;
         is_div  <= 1'b0;
         cnt     <= '0;
         acc     <= '0;
         mcand   <= '0;
         opa     <= '0;
         divisor <= '0;
         rem     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (is_slow_op) begin
                     state   <= RUN;
                     is_div  <= (alu_op == OP_DIV);
                     cnt     <= CW'(WIDTH-1);
                     acc     <= '0;
                     mcand   <= {{WIDTH{1'b0}}, data_in1};
                     opa     <= (alu_op == OP_DIV) ? data_in1 : data_in2;
                     divisor <= data_in2;
                     rem     <= '0;
                  end else begin
                     result <= fast_res;
                     zero   <= (fast_res == '0);
                     div0   <= 1'b0;
                     done   <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (is_div) begin
                  rem <= rem_nxt;
                  opa <= quo_nxt;
               end else begin
                  acc   <= mul_acc_nxt;
                  mcand <= mcand << 1;
                  opa   <= opa >> 1;
               end
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  state  <= IDLE;
                  done   <= 1'b1;
                  result <= slow_res;
                  zero   <= (slow_res == '0);
                  div0   <= is_div && (divisor == '0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
